// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller.
//   - Condition-code encodings (cond[2:0]; cond[3] is never decoded)
//   - Bit positions of the committed flags inside the 3-bit zvn vector
//   - FSM state encoding
package branch_resolve_ctrl_pkg;

   // Condition codes
   localparam logic [2:0] COND_EQ   = 3'b000;
   localparam logic [2:0] COND_LT   = 3'b001;
   localparam logic [2:0] COND_GT   = 3'b010;
   localparam logic [2:0] COND_OVF  = 3'b011;
   localparam logic [2:0] COND_NE   = 3'b100;
   localparam logic [2:0] COND_GE   = 3'b101;
   localparam logic [2:0] COND_LE   = 3'b110;
   localparam logic [2:0] COND_TRUE = 3'b111;

   // Flag positions within zvn = {z, v, n}
   localparam int unsigned ZVN_N = 0;
   localparam int unsigned ZVN_V = 1;
   localparam int unsigned ZVN_Z = 2;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWait    = 2'd1,
      StResolve = 2'd2,
      StFlush   = 2'd3
   } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   i_cond  [2:0]  condition code (EQ..TRUE)
//   i_zvn   [2:0]  committed flags {z, v, n}
//   o_taken        1 when the condition holds for the given flags
module branch_resolve_ctrl_cond_eval
   import branch_resolve_ctrl_pkg::*;
(
   input  logic [2:0] i_cond,
   input  logic [2:0] i_zvn,
   output logic       o_taken
);

   logic w_z;
   logic w_v;
   logic w_n;

   assign w_z = i_zvn[ZVN_Z];
   assign w_v = i_zvn[ZVN_V];
   assign w_n = i_zvn[ZVN_N];

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         COND_EQ:   o_taken = w_z;
         COND_LT:   o_taken = ~w_v & w_n;
         COND_GT:   o_taken = (i_zvn == 3'b000);
         COND_OVF:  o_taken = w_v;
         COND_NE:   o_taken = ~w_z;
         COND_GE:   o_taken = ~w_v & ~w_n;
         COND_LE:   o_taken = (w_n & ~w_v) | w_z;
         COND_TRUE: o_taken = 1'b1;
         default:   o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution controller.
// Accepts one branch at a time, stalls the front end until every older
// flag writer has committed, evaluates the condition against its own
// committed zvn copy, and on a taken branch pulses a redirect followed by
// a FLUSH_CYCLES-long flush.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_br_valid/o_br_ready   branch handshake from decode
//   i_br_cond, i_br_target  condition code (bit 3 unused), taken target
//   i_fw_issue, i_fw_commit flag writer enters EX / commits
//   i_fw_z/v/n              flags delivered with a commit
//   o_stall                 hold fetch/decode
//   o_taken                 outcome, valid in the resolve cycle
//   o_redirect_valid/pc     one-cycle redirect pulse, latched target
//   o_flush                 squash younger instructions
//   o_pend_err              sticky pending-counter over/underflow
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned MAX_PEND     = 3,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_br_valid,
   output logic              o_br_ready,
   input  logic [3:0]        i_br_cond,
   input  logic [ADDR_W-1:0] i_br_target,
   input  logic              i_fw_issue,
   input  logic              i_fw_commit,
   input  logic              i_fw_z,
   input  logic              i_fw_v,
   input  logic              i_fw_n,
   output logic              o_stall,
   output logic              o_taken,
   output logic              o_redirect_valid,
   output logic [ADDR_W-1:0] o_redirect_pc,
   output logic              o_flush,
   output logic              o_pend_err
);

   localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
   localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES);
   localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

   state_t              r_state;
   state_t              w_state_d;
   logic [PEND_W-1:0]   r_pend;
   logic [PEND_W-1:0]   w_pend_d;
   logic                r_pend_err;
   logic                w_pend_err_d;
   logic [2:0]          r_zvn;
   logic [2:0]          w_zvn_d;
   logic [2:0]          r_cond;
   logic [2:0]          w_cond_d;
   logic [ADDR_W-1:0]   r_target;
   logic [ADDR_W-1:0]   w_target_d;
   logic [FCNT_W-1:0]   r_fcnt;
   logic [FCNT_W-1:0]   w_fcnt_d;
   logic                w_cond_taken;
   logic                w_unused_cond;

   // Condition bit 3 is architecturally ignored.
   assign w_unused_cond = i_br_cond[3];

   branch_resolve_ctrl_cond_eval u_cond_eval (
      .i_cond  (r_cond),
      .i_zvn   (r_zvn),
      .o_taken (w_cond_taken)
   );

   // Flag copy and pending-writer counter. Simultaneous issue and commit
   // cancel; an underflowing commit still delivers its flags.
   always_comb begin
      w_zvn_d      = r_zvn;
      w_pend_d     = r_pend;
      w_pend_err_d = r_pend_err;
      if (i_fw_commit) begin
         w_zvn_d[ZVN_Z] = i_fw_z;
         w_zvn_d[ZVN_V] = i_fw_v;
         w_zvn_d[ZVN_N] = i_fw_n;
      end
      if (i_fw_issue && !i_fw_commit) begin
         if (r_pend == PEND_MAX) begin
            w_pend_err_d = 1'b1;
         end else begin
            w_pend_d = r_pend + PEND_ONE;
         end
      end else if (i_fw_commit && !i_fw_issue) begin
         if (r_pend == '0) begin
            w_pend_err_d = 1'b1;
         end else begin
            w_pend_d = r_pend - PEND_ONE;
         end
      end
   end

   // Next-state and outputs. Resolution uses the registered zvn, so a
   // commit landing in the resolve cycle cannot change the outcome.
   always_comb begin
      w_state_d        = r_state;
      w_fcnt_d         = r_fcnt;
      w_cond_d         = r_cond;
      w_target_d       = r_target;
      o_br_ready       = 1'b0;
      o_stall          = 1'b1;
      o_taken          = 1'b0;
      o_redirect_valid = 1'b0;
      o_flush          = 1'b0;
      case (r_state)
         StIdle: begin
            o_br_ready = 1'b1;
            o_stall    = 1'b0;
            if (i_br_valid) begin
               w_cond_d   = i_br_cond[2:0];
               w_target_d = i_br_target;
               w_state_d  = StWait;
            end
         end
         StWait: begin
            // A writer issuing this cycle is older than the branch.
            if ((r_pend == '0) && !i_fw_issue) begin
               w_state_d = StResolve;
            end
         end
         StResolve: begin
            o_taken          = w_cond_taken;
            o_redirect_valid = w_cond_taken;
            if (w_cond_taken) begin
               w_fcnt_d  = FCNT_INIT;
               w_state_d = StFlush;
            end else begin
               w_state_d = StIdle;
            end
         end
         StFlush: begin
            o_flush  = 1'b1;
            w_fcnt_d = r_fcnt - FCNT_ONE;
            if (r_fcnt == FCNT_ONE) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign o_redirect_pc = r_target;
   assign o_pend_err    = r_pend_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_pend     <= '0;
         r_pend_err <= 1'b0;
         r_zvn      <= '0;
         r_cond     <= '0;
         r_target   <= '0;
         r_fcnt     <= '0;
      end else begin
         r_state    <= w_state_d;
         r_pend     <= w_pend_d;
         r_pend_err <= w_pend_err_d;
         r_zvn      <= w_zvn_d;
         r_cond     <= w_cond_d;
         r_target   <= w_target_d;
         r_fcnt     <= w_fcnt_d;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: reference model checked every
// cycle, directed sequences, a condition table and a randomized run.
module tb_branch_resolve_ctrl;

   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned MAX_PEND     = 3;
   localparam int unsigned FLUSH_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              br_valid;
   logic              br_ready;
   logic [3:0]        br_cond;
   logic [ADDR_W-1:0] br_target;
   logic              fw_issue;
   logic              fw_commit;
   logic              fw_z;
   logic              fw_v;
   logic              fw_n;
   logic              stall;
   logic              taken;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;
   logic              pend_err;

   branch_resolve_ctrl #(
      .ADDR_W       (ADDR_W),
      .MAX_PEND     (MAX_PEND),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_br_valid       (br_valid),
      .o_br_ready       (br_ready),
      .i_br_cond        (br_cond),
      .i_br_target      (br_target),
      .i_fw_issue       (fw_issue),
      .i_fw_commit      (fw_commit),
      .i_fw_z           (fw_z),
      .i_fw_v           (fw_v),
      .i_fw_n           (fw_n),
      .o_stall          (stall),
      .o_taken          (taken),
      .o_redirect_valid (redirect_valid),
      .o_redirect_pc    (redirect_pc),
      .o_flush          (flush),
      .o_pend_err       (pend_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 idle, 1 waiting, 2 resolving, 3 flushing.
   int          m_phase;
   int          m_fl;
   int          m_pend;
   logic [2:0]  m_zvn;
   logic [2:0]  m_cond;
   logic [15:0] m_tgt;
   logic        m_err;

   // Outputs sampled mid-cycle by cycle()
   logic        s_ready, s_stall, s_taken, s_rv, s_flush, s_err;
   logic [15:0] s_pc;

   typedef struct {
      logic [3:0] cond;
      logic [2:0] zvn;
      logic       exp;
   } vec_t;
   vec_t tbl[16];

   function automatic logic spec_taken(logic [2:0] c, logic [2:0] zvn);
      logic z, v, n;
      z = zvn[2];
      v = zvn[1];
      n = zvn[0];
      case (c)
         3'd0:    return z;
         3'd1:    return !v && n;
         3'd2:    return zvn == 3'b000;
         3'd3:    return v;
         3'd4:    return !z;
         3'd5:    return !v && !n;
         3'd6:    return (n && !v) || z;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] exp_o(logic r, logic s, logic t, logic rv, logic f, logic e,
                                         logic [15:0] pc);
      return {10'd0, r, s, t, rv, f, e, pc};
   endfunction

   function automatic logic [31:0] pack_s();
      return {10'd0, s_ready, s_stall, s_taken, s_rv, s_flush, s_err, s_pc};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      br_valid  = 1'b0;
      br_cond   = 4'h0;
      br_target = '0;
      fw_issue  = 1'b0;
      fw_commit = 1'b0;
      fw_z      = 1'b0;
      fw_v      = 1'b0;
      fw_n      = 1'b0;
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_fl    = 0;
      m_pend  = 0;
      m_zvn   = 3'b000;
      m_cond  = 3'b000;
      m_tgt   = 16'h0000;
      m_err   = 1'b0;
   endtask

   task automatic model_step();
      logic t;
      t = spec_taken(m_cond, m_zvn);
      case (m_phase)
         0: if (br_valid) begin
               m_cond  = br_cond[2:0];
               m_tgt   = br_target;
               m_phase = 1;
            end
         1: if (m_pend == 0 && !fw_issue) m_phase = 2;
         2: if (t) begin
               m_phase = 3;
               m_fl    = FLUSH_CYCLES;
            end else begin
               m_phase = 0;
            end
         default: begin
            m_fl--;
            if (m_fl == 0) m_phase = 0;
         end
      endcase
      if (fw_issue && !fw_commit) begin
         if (m_pend == MAX_PEND) m_err = 1'b1;
         else m_pend++;
      end else if (fw_commit && !fw_issue) begin
         if (m_pend == 0) m_err = 1'b1;
         else m_pend--;
      end
      if (fw_commit) m_zvn = {fw_z, fw_v, fw_n};
   endtask

   // One clock: inputs already driven; sample at negedge, compare to model,
   // advance model at posedge, return 1ns after the edge.
   task automatic cycle();
      logic exp_t;
      @(negedge clk);
      s_ready = br_ready;
      s_stall = stall;
      s_taken = taken;
      s_rv    = redirect_valid;
      s_flush = flush;
      s_err   = pend_err;
      s_pc    = redirect_pc;
      exp_t   = (m_phase == 2) && spec_taken(m_cond, m_zvn);
      chk("model", pack_s(), exp_o(m_phase == 0, m_phase != 0, exp_t, exp_t, m_phase == 3,
                                   m_err, m_tgt));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_branch(input logic [3:0] c, input logic [2:0] zvn, output logic tk);
      fw_issue = 1'b1;
      cycle();
      clr_in();
      fw_commit = 1'b1;
      {fw_z, fw_v, fw_n} = zvn;
      cycle();
      clr_in();
      br_valid  = 1'b1;
      br_cond   = c;
      br_target = 16'($urandom);
      cycle();
      clr_in();
      cycle();
      cycle();
      tk = s_taken;
      repeat (3) cycle();
   endtask

   initial begin
      logic tk;
      clr_in();
      model_reset();

      // Basic taken EQ branch, minimum latency
      do_reset();
      cycle();
      chk("reset_state", pack_s(), exp_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      fw_issue = 1'b1;
      cycle();
      clr_in();
      fw_commit = 1'b1;
      fw_z = 1'b1;
      cycle();
      clr_in();
      br_valid = 1'b1;
      br_cond = 4'h0;
      br_target = 16'h0040;
      cycle();
      chk("eq_t0", pack_s(), exp_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
      clr_in();
      cycle();
      chk("eq_t1", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040));
      cycle();
      chk("eq_t2", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040));
      cycle();
      chk("eq_t3", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040));
      cycle();
      chk("eq_t4", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040));
      cycle();
      chk("eq_t5", pack_s(), exp_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040));

      // Branch waits for an older writer; commit registered at the T+4 edge
      do_reset();
      fw_issue = 1'b1;
      cycle();
      clr_in();
      br_valid = 1'b1;
      br_cond = 4'h1;
      br_target = 16'h1234;
      cycle();
      clr_in();
      cycle();
      chk("lt_wait2", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234));
      fw_commit = 1'b1;
      fw_n = 1'b1;
      cycle();
      clr_in();
      chk("lt_wait3", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234));
      cycle();
      chk("lt_wait4", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234));
      cycle();
      chk("lt_resolve5", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234));
      repeat (3) cycle();

      // zvn=000: NE taken, LE not taken
      do_reset();
      br_valid = 1'b1;
      br_cond = 4'h4;
      br_target = 16'h0100;
      cycle();
      clr_in();
      cycle();
      cycle();
      chk("ne_taken", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100));
      cycle();
      cycle();
      br_valid = 1'b1;
      br_cond = 4'h6;
      br_target = 16'h0200;
      cycle();
      clr_in();
      cycle();
      cycle();
      chk("le_not_taken", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0200));
      cycle();
      chk("le_idle", pack_s(), exp_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0200));

      // Issue+commit together keeps pend at 1; overflow saturates at MAX_PEND
      do_reset();
      fw_issue = 1'b1;
      cycle();
      fw_commit = 1'b1;
      cycle();
      clr_in();
      br_valid = 1'b1;
      br_cond = 4'h7;
      br_target = 16'h0300;
      cycle();
      clr_in();
      repeat (3) begin
         cycle();
         chk("both_hold", pack_s(), exp_o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0300));
      end
      fw_commit = 1'b1;
      cycle();
      clr_in();
      cycle();
      cycle();
      chk("both_resolve", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300));
      cycle();
      cycle();
      fw_issue = 1'b1;
      repeat (4) cycle();
      clr_in();
      cycle();
      chk("overflow_err", 32'(s_err), 32'(1'b1));
      fw_commit = 1'b1;
      repeat (3) cycle();
      clr_in();
      br_valid = 1'b1;
      br_cond = 4'h7;
      br_target = 16'h0400;
      cycle();
      clr_in();
      cycle();
      cycle();
      chk("sat_drained", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0400));
      cycle();
      cycle();

      // Asynchronous reset during FLUSH, then zvn must read back as 000
      do_reset();
      fw_issue = 1'b1;
      cycle();
      clr_in();
      fw_commit = 1'b1;
      fw_z = 1'b1;
      fw_v = 1'b1;
      cycle();
      clr_in();
      br_valid = 1'b1;
      br_cond = 4'h7;
      br_target = 16'h0500;
      cycle();
      clr_in();
      cycle();
      cycle();
      cycle();
      chk("flush_before_rst", 32'(flush), 32'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {28'd0, flush, stall, br_ready, redirect_valid}, 32'h2);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      br_valid = 1'b1;
      br_cond = 4'h2;
      br_target = 16'h0600;
      cycle();
      clr_in();
      cycle();
      cycle();
      chk("gt_after_rst", pack_s(), exp_o(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0600));
      repeat (3) cycle();

      // Hand-written condition table rows (zvn = {z,v,n})
      tbl[0]  = '{4'h0, 3'b100, 1'b1};
      tbl[1]  = '{4'h0, 3'b000, 1'b0};
      tbl[2]  = '{4'h1, 3'b001, 1'b1};
      tbl[3]  = '{4'h1, 3'b011, 1'b0};
      tbl[4]  = '{4'h2, 3'b000, 1'b1};
      tbl[5]  = '{4'h2, 3'b001, 1'b0};
      tbl[6]  = '{4'h3, 3'b010, 1'b1};
      tbl[7]  = '{4'h3, 3'b101, 1'b0};
      tbl[8]  = '{4'h4, 3'b000, 1'b1};
      tbl[9]  = '{4'h4, 3'b100, 1'b0};
      tbl[10] = '{4'h5, 3'b000, 1'b1};
      tbl[11] = '{4'h5, 3'b001, 1'b0};
      tbl[12] = '{4'h6, 3'b100, 1'b1};
      tbl[13] = '{4'h6, 3'b011, 1'b0};
      tbl[14] = '{4'hA, 3'b000, 1'b1};
      tbl[15] = '{4'h8, 3'b010, 1'b0};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         run_branch(tbl[i].cond, tbl[i].zvn, tk);
         chk($sformatf("tbl%0d", i), 32'(tk), 32'(tbl[i].exp));
      end

      // Full sweep, cond bit 3 randomized
      for (int c = 0; c < 8; c++) begin
         for (int z = 0; z < 8; z++) begin
            run_branch({1'($urandom), 3'(c)}, 3'(z), tk);
            chk($sformatf("sweep_c%0d_z%0d", c, z), 32'(tk), 32'(spec_taken(3'(c), 3'(z))));
         end
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         fw_issue  = ($urandom_range(9) < 3);
         fw_commit = ($urandom_range(9) < 3);
         fw_z      = 1'($urandom);
         fw_v      = 1'($urandom);
         fw_n      = 1'($urandom);
         br_valid  = ($urandom_range(9) < 4);
         br_cond   = 4'($urandom);
         br_target = 16'($urandom);
         cycle();
      end
      clr_in();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences conditional-branch resolution against the ZVN flag state. It accepts one branch at a time from decode and tracks in-flight flag-writing instructions. It stalls the front end until all older flag writers have committed, then evaluates the condition and issues a PC redirect plus a timed pipeline flush when the branch is taken. It owns its own committed ZVN copy, so it is the single authority for branch outcome.

Parameters:
ADDR_W, 16, width of PC/target addresses
MAX_PEND, 3, max in-flight flag writers tracked (counter saturates here)
FLUSH_CYCLES, 2, cycles flush is held after a taken redirect (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
br_valid  in  1  decode presents a branch
br_ready  out  1  controller can accept a branch
br_cond  in  4  condition code; bit 3 ignored
br_target  in  ADDR_W  taken target PC
fw_issue  in  1  flag-writing instruction entered EX this cycle
fw_commit  in  1  flag writer commits z/v/n this cycle
fw_z  in  1  committed zero flag
fw_v  in  1  committed overflow flag
fw_n  in  1  committed negative flag
stall  out  1  hold fetch/decode
taken  out  1  resolved outcome, valid while redirect_valid or resolve cycle
redirect_valid  out  1  one-cycle pulse: load redirect_pc
redirect_pc  out  ADDR_W  latched br_target
flush  out  1  squash younger instructions
pend_err  out  1  sticky: counter over/underflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, zvn=000, pend=0, latched cond/target=0, pend_err=0. Outputs: br_ready=1, stall=0, taken=0, redirect_valid=0, redirect_pc=0, flush=0.
- Flag copy zvn: loaded from {fw_z,fw_v,fw_n} at the clock edge where fw_commit=1.
- Pending counter pend: +1 on fw_issue only, -1 on fw_commit only, unchanged when both or neither are asserted. Issue with pend==MAX_PEND: hold at MAX_PEND and set pend_err. Commit with pend==0: stay 0, set pend_err, zvn still updates.
- Condition table (cond[2:0]): 000 EQ=Z; 001 LT=~V&N; 010 GT=(zvn==000); 011 OVF=V; 100 NE=~Z; 101 GE=~V&~N; 110 LE=(N&~V)|Z; 111 TRUE=1.
- FSM states: IDLE, WAIT, RESOLVE, FLUSH.
  - IDLE: br_ready=1, stall=0. On br_valid latch cond/target and go to WAIT.
  - WAIT: stall=1. Go to RESOLVE when pend==0 (registered value) and fw_issue==0; otherwise stay.
  - RESOLVE: one cycle, stall=1. taken=cond_eval(latched cond, zvn), using pre-edge zvn; a commit in this cycle does not affect the outcome. If taken: redirect_valid=1, go to FLUSH with the flush counter loaded to FLUSH_CYCLES. If not taken: go to IDLE, no redirect.
  - FLUSH: flush=1 and stall=1. Decrement the counter each cycle; go to IDLE after FLUSH_CYCLES cycles.
- br_ready=0 in every state except IDLE. br_valid outside IDLE is ignored.
- Minimum latency: accept at T, RESOLVE at T+2, redirect pulse in T+2, flush in T+3..T+2+FLUSH_CYCLES.
- redirect_pc holds the latched target until the next accept.
- Mid-operation reset returns to IDLE immediately. No redirect or flush is emitted.

Decomposition:
- Shared package: condition-code constants (EQ..TRUE), ZVN bit-index constants (N=0, V=1, Z=2), FSM state encoding.
- One natural combinational sub-module, cond_eval (cond[2:0], zvn -> taken), so the table is defined once and tested standalone.

Test Plan:
- pend=0, zvn=100, br_valid with cond=000, target=0x0040 -> taken=1, redirect_valid pulse at T+2 with redirect_pc=0x0040, flush high 2 cycles, back in IDLE at T+5.
- fw_issue at T, branch cond=001 accepted at T+1, fw_commit z=0,v=0,n=1 at T+4 -> stall held through WAIT, RESOLVE at T+5, taken=1.
- zvn=000, cond=100 (NE) -> RESOLVE taken=1. cond=110 (LE) -> taken=0, no redirect or flush, IDLE the next cycle.
- fw_issue and fw_commit in the same cycle with pend=1 -> pend stays 1. Four issues with MAX_PEND=3 -> pend=3 and pend_err=1.
- rst_n low during FLUSH -> flush=0, stall=0, br_ready=1 asynchronously, and zvn=000.
- Sweep all 8 codes against all 8 zvn values -> taken matches the condition table, including cond bit 3 = 1 (ignored).
